tag_ctrl: RTL and testbench



---
 rtl/tag_ctrl.sv | 123 ++++++++++++
 tb/tb_tag_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ctrl.sv
// rtl/tag_ctrl.sv - 64-entry 3-bit cache tag store with fill/invalidate write port, flush sweep and registered lookup
module tag_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [5:0] ad_i,
  input  logic [2:0] tag_i,
  output logic [2:0] tag_o,
  output logic       hit_o,
  input  logic       wr_req_i,
  input  logic [5:0] wr_ad_i,
  input  logic [2:0] wr_tag_i,
  input  logic       wr_valid_i,
  output logic       wr_ack_o,
  input  logic       flush_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;

  // Entry layout: {valid, tag[2:0]}
  logic [3:0] r_mem [64];

  logic       w_we;
  logic [5:0] w_wad;
  logic [3:0] w_wdata;
  logic [3:0] w_rd;

  logic [5:0] r_ad;
  logic [2:0] r_tag;
  logic [2:0] r_tag_out;
  logic       r_hit;
  logic       w_busy;

  assign w_busy   = (r_state == S_FLUSH);
  assign busy_o   = w_busy;
  // The ack is dropped in the very cycle reset is raised, so a reset during ACK never shows a pulse
  assign wr_ack_o = (r_state == S_ACK) && !reset_i;
  assign tag_o    = r_tag_out;
  assign hit_o    = r_hit;
  assign w_rd     = r_mem[r_ad];

  // State and sweep-counter register; reset restarts the clearing sweep from entry 0
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_FLUSH;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and single write-port arbitration: sweep owns the port in FLUSH, requester in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_wad       = r_cnt;
    w_wdata     = 4'b0000;
    case (r_state)
      S_FLUSH: begin
        w_we      = 1'b1;
        w_wad     = r_cnt;
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == 6'd63) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (wr_req_i && !flush_i) begin
          w_we        = 1'b1;
          w_wad       = wr_ad_i;
          w_wdata     = {wr_valid_i, wr_tag_i};
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = 6'd0;
      end
    endcase
    // A flush request overrides everything and restarts the sweep
    if (flush_i) begin
      w_state_nxt = S_FLUSH;
      w_cnt_nxt   = 6'd0;
    end
  end

  // Tag RAM write: no reset on the array itself, the sweep clears it; no write is committed under reset
  always_ff @(posedge clock_i) begin
    if (w_we && !reset_i) begin
      r_mem[w_wad] <= w_wdata;
    end
  end

  // Lookup pipeline: register index/tag, then register the RAM read and compare (old data on same-edge write)
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_ad      <= 6'd0;
      r_tag     <= 3'd0;
      r_tag_out <= 3'd0;
      r_hit     <= 1'b0;
    end else begin
      r_ad      <= ad_i;
      r_tag     <= tag_i;
      r_tag_out <= w_rd[2:0];
      r_hit     <= w_rd[3] && (w_rd[2:0] == r_tag) && !w_busy;
    end
  end

endmodule

// File: tb/tb_tag_ctrl.sv
// tb/tb_tag_ctrl.sv - self-checking bench for tag_ctrl with a cycle-level behavioural reference
module tb_tag_ctrl;

  logic       clk;
  logic       reset_i;
  logic [5:0] ad_i;
  logic [2:0] tag_i;
  logic [2:0] tag_o;
  logic       hit_o;
  logic       wr_req_i;
  logic [5:0] wr_ad_i;
  logic [2:0] wr_tag_i;
  logic       wr_valid_i;
  logic       wr_ack_o;
  logic       flush_i;
  logic       busy_o;

  int vectors;
  int miscompares;

  tag_ctrl dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .ad_i       (ad_i),
    .tag_i      (tag_i),
    .tag_o      (tag_o),
    .hit_o      (hit_o),
    .wr_req_i   (wr_req_i),
    .wr_ad_i    (wr_ad_i),
    .wr_tag_i   (wr_tag_i),
    .wr_valid_i (wr_valid_i),
    .wr_ack_o   (wr_ack_o),
    .flush_i    (flush_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: tag table as plain arrays, flush modelled as "cycles of sweep left", ack as a pending flag
  logic       m_v [64];
  logic [2:0] m_t [64];
  int         m_left;
  logic       m_ack;
  logic [5:0] m_ad;
  logic [2:0] m_tg;
  logic [2:0] e_tag;
  logic       e_hit;
  logic [5:0] m_clr;

  assign m_clr = 6'(64 - m_left);

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0;
      m_t[i] = 3'd0;
    end
    m_left = 64;
    m_ack  = 1'b0;
    m_ad   = 6'd0;
    m_tg   = 3'd0;
    e_tag  = 3'd0;
    e_hit  = 1'b0;
  end

  always @(posedge clk) begin
    if (reset_i) begin
      m_left <= 64;
      m_ack  <= 1'b0;
      m_ad   <= 6'd0;
      m_tg   <= 3'd0;
      e_tag  <= 3'd0;
      e_hit  <= 1'b0;
    end else begin
      e_tag <= m_t[m_ad];
      e_hit <= m_v[m_ad] && (m_t[m_ad] == m_tg) && (m_left == 0);
      m_ad  <= ad_i;
      m_tg  <= tag_i;
      m_ack <= 1'b0;
      if (m_left > 0) begin
        m_v[m_clr] <= 1'b0;
        m_t[m_clr] <= 3'd0;
        m_left     <= m_left - 1;
      end else if (!m_ack && wr_req_i && !flush_i) begin
        m_v[wr_ad_i] <= wr_valid_i;
        m_t[wr_ad_i] <= wr_tag_i;
        m_ack        <= 1'b1;
      end
      if (flush_i) begin
        m_left <= 64;
        m_ack  <= 1'b0;
      end
    end
  end

  task automatic do_write(input logic [5:0] a, input logic [2:0] t, input logic v, output int lat);
    wr_req_i   = 1'b1;
    wr_ad_i    = a;
    wr_tag_i   = t;
    wr_valid_i = v;
    lat        = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (wr_ack_o) begin
        lat = i;
        break;
      end
    end
    wr_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic lookup(input logic [5:0] a, input logic [2:0] t,
                        output logic [2:0] ot, output logic oh,
                        output logic [2:0] et, output logic eh);
    ad_i  = a;
    tag_i = t;
    @(negedge clk);
    @(negedge clk);
    ot = tag_o;
    oh = hit_o;
    et = e_tag;
    eh = e_hit;
  endtask

  task automatic test_reset;
    int n;
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (busy_o !== 1'b1)   begin miscompares++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
    if (wr_ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", wr_ack_o); end
    if (tag_o !== 3'd0)    begin miscompares++; $display("FAIL reset_tag got=%0d exp=0", tag_o); end
    if (hit_o !== 1'b0)    begin miscompares++; $display("FAIL reset_hit got=%b exp=0", hit_o); end
    reset_i = 1'b0;
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_o) n++;
      else break;
    end
    vectors++;
    if (n != 64) begin miscompares++; $display("FAIL reset_busy_len got=%0d exp=64", n); end
    tag_i = 3'd0;
    for (int i = 0; i < 66; i++) begin
      if (i >= 2) begin
        vectors += 3;
        if (hit_o !== 1'b0) begin miscompares++; $display("FAIL clear_hit idx=%0d got=%b exp=0", i - 2, hit_o); end
        if (tag_o !== 3'd0) begin miscompares++; $display("FAIL clear_tag idx=%0d got=%0d exp=0", i - 2, tag_o); end
        if (hit_o !== e_hit) begin miscompares++; $display("FAIL clear_model idx=%0d got=%b exp=%b", i - 2, hit_o, e_hit); end
      end
      ad_i = 6'(i);
      @(negedge clk);
    end
  endtask

  task automatic test_fill;
    int lat;
    logic [2:0] ot, et;
    logic oh, eh;
    do_write(6'h15, 3'd5, 1'b1, lat);
    vectors += 2;
    if (lat != 1) begin miscompares++; $display("FAIL fill_ack_lat got=%0d exp=1", lat); end
    if (wr_ack_o !== 1'b0) begin miscompares++; $display("FAIL fill_ack_pulse got=%b exp=0", wr_ack_o); end
    lookup(6'h15, 3'd5, ot, oh, et, eh);
    vectors += 3;
    if (oh !== 1'b1) begin miscompares++; $display("FAIL fill_hit got=%b exp=1", oh); end
    if (ot !== 3'd5) begin miscompares++; $display("FAIL fill_tag got=%0d exp=5", ot); end
    if (oh !== eh)   begin miscompares++; $display("FAIL fill_model got=%b exp=%b", oh, eh); end
    lookup(6'h15, 3'd4, ot, oh, et, eh);
    vectors += 2;
    if (oh !== 1'b0) begin miscompares++; $display("FAIL fill_miss_hit got=%b exp=0", oh); end
    if (ot !== 3'd5) begin miscompares++; $display("FAIL fill_miss_tag got=%0d exp=5", ot); end
  endtask

  task automatic test_invalidate;
    int lat;
    logic [2:0] nt, ot, et;
    logic oh, eh;
    nt = 3'($urandom_range(0, 7));
    do_write(6'h3E, nt, 1'b1, lat);
    do_write(6'h3F, 3'd7, 1'b1, lat);
    do_write(6'h3F, 3'($urandom_range(0, 7)), 1'b0, lat);
    vectors++;
    if (lat != 1) begin miscompares++; $display("FAIL inval_ack_lat got=%0d exp=1", lat); end
    lookup(6'h3F, 3'd7, ot, oh, et, eh);
    vectors++;
    if (oh !== 1'b0) begin miscompares++; $display("FAIL inval_hit got=%b exp=0", oh); end
    lookup(6'h3E, nt, ot, oh, et, eh);
    vectors += 2;
    if (oh !== 1'b1) begin miscompares++; $display("FAIL neighbor_hit got=%b exp=1", oh); end
    if (ot !== nt)   begin miscompares++; $display("FAIL neighbor_tag got=%0d exp=%0d", ot, nt); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] acks;
    logic [5:0] macks;
    acks  = 6'd0;
    macks = 6'd0;
    wr_req_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      wr_ad_i    = 6'($urandom_range(0, 63));
      wr_tag_i   = 3'($urandom_range(0, 7));
      wr_valid_i = 1'b1;
      @(negedge clk);
      acks[c]  = wr_ack_o;
      macks[c] = m_ack;
      if (c == 5) wr_req_i = 1'b0;
    end
    @(negedge clk);
    vectors += 2;
    if (acks !== 6'b010101) begin miscompares++; $display("FAIL b2b_acks got=%b exp=010101", acks); end
    if (acks !== macks)     begin miscompares++; $display("FAIL b2b_model got=%b exp=%b", acks, macks); end
  endtask

  task automatic test_flush_collision;
    int lat, n, acks;
    logic [2:0] ot, et;
    logic oh, eh;
    logic [2:0] tg [10];
    for (int i = 0; i < 10; i++) begin
      tg[i] = 3'($urandom_range(0, 7));
      do_write(6'(i * 5 + 1), tg[i], 1'b1, lat);
    end
    flush_i    = 1'b1;
    wr_req_i   = 1'b1;
    wr_ad_i    = 6'd40;
    wr_tag_i   = 3'($urandom_range(0, 7));
    wr_valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n = 0;
    acks = 0;
    for (int k = 0; k < 200; k++) begin
      if (wr_ack_o) acks++;
      if (!busy_o) break;
      n++;
      @(negedge clk);
    end
    vectors += 2;
    if (n != 64)   begin miscompares++; $display("FAIL flush_busy_len got=%0d exp=64", n); end
    if (acks != 0) begin miscompares++; $display("FAIL flush_ack_suppress got=%0d exp=0", acks); end
    @(negedge clk);
    vectors++;
    if (wr_ack_o !== 1'b1) begin miscompares++; $display("FAIL flush_req_after got=%b exp=1", wr_ack_o); end
    wr_req_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      lookup(6'(i * 5 + 1), tg[i], ot, oh, et, eh);
      vectors += 2;
      if (oh !== 1'b0) begin miscompares++; $display("FAIL flush_miss idx=%0d got=%b exp=0", i * 5 + 1, oh); end
      if (ot !== et)   begin miscompares++; $display("FAIL flush_tag idx=%0d got=%0d exp=%0d", i * 5 + 1, ot, et); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (29) @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 3;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rmid_busy got=%b exp=1", busy_o); end
    if (tag_o !== 3'd0)  begin miscompares++; $display("FAIL rmid_tag got=%0d exp=0", tag_o); end
    if (hit_o !== 1'b0)  begin miscompares++; $display("FAIL rmid_hit got=%b exp=0", hit_o); end
    reset_i = 1'b0;
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_o) n++;
      else break;
    end
    vectors++;
    if (n != 64) begin miscompares++; $display("FAIL rmid_busy_len got=%0d exp=64", n); end
    wr_req_i   = 1'b1;
    wr_ad_i    = 6'($urandom_range(0, 63));
    wr_tag_i   = 3'($urandom_range(0, 7));
    wr_valid_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_ack_o !== 1'b1) begin miscompares++; $display("FAIL rack_pre got=%b exp=1", wr_ack_o); end
    wr_req_i = 1'b0;
    reset_i  = 1'b1;
    #1;
    vectors++;
    if (wr_ack_o !== 1'b0) begin miscompares++; $display("FAIL rack_suppress got=%b exp=0", wr_ack_o); end
    @(negedge clk);
    @(negedge clk);
    vectors += 4;
    if (wr_ack_o !== 1'b0) begin miscompares++; $display("FAIL rack_reset_ack got=%b exp=0", wr_ack_o); end
    if (busy_o !== 1'b1)   begin miscompares++; $display("FAIL rack_reset_busy got=%b exp=1", busy_o); end
    if (tag_o !== 3'd0)    begin miscompares++; $display("FAIL rack_reset_tag got=%0d exp=0", tag_o); end
    if (hit_o !== 1'b0)    begin miscompares++; $display("FAIL rack_reset_hit got=%b exp=0", hit_o); end
    reset_i = 1'b0;
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_o) n++;
      else break;
    end
    vectors++;
    if (n != 64) begin miscompares++; $display("FAIL rack_busy_len got=%0d exp=64", n); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 1500; c++) begin
      vectors += 4;
      if (wr_ack_o !== m_ack)        begin miscompares++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, wr_ack_o, m_ack); end
      if (busy_o !== (m_left > 0))   begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy_o, m_left > 0); end
      if (hit_o !== e_hit)           begin miscompares++; $display("FAIL rnd_hit cyc=%0d got=%b exp=%b", c, hit_o, e_hit); end
      if (tag_o !== e_tag)           begin miscompares++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", c, tag_o, e_tag); end
      ad_i       = 6'($urandom_range(0, 63));
      tag_i      = 3'($urandom_range(0, 7));
      wr_req_i   = ($urandom_range(0, 1) == 1);
      wr_ad_i    = ($urandom_range(0, 1) == 1) ? ad_i : 6'($urandom_range(0, 63));
      wr_tag_i   = 3'($urandom_range(0, 7));
      wr_valid_i = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    flush_i  = 1'b0;
    wr_req_i = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_i     = 1'b1;
    ad_i        = 6'd0;
    tag_i       = 3'd0;
    wr_req_i    = 1'b0;
    wr_ad_i     = 6'd0;
    wr_tag_i    = 3'd0;
    wr_valid_i  = 1'b0;
    flush_i     = 1'b0;
    @(negedge clk);
    test_reset;
    test_fill;
    test_invalidate;
    test_back_to_back;
    test_flush_collision;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
